// File: rtl/bcd_timer_seg_ctl.sv
// Host-programmable N-digit BCD up/down timer with multiplexed 7-segment scan
// and level interrupt, attached to the HOST_nCS/nWE/nOE register bus.
module bcd_timer_seg_ctl #(
  parameter int unsigned DIGITS   = 6,
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned SCAN_DIV = 25000
) (
  input  logic              clk,
  input  logic              nRESET,
  input  logic              HOST_nCS,
  input  logic              HOST_nWE,
  input  logic              HOST_nOE,
  input  logic [3:0]        HOST_ADD,
  input  logic [15:0]       HDI,
  output logic [15:0]       HDO,
  output logic [DIGITS-1:0] SEG_COM,
  output logic [7:0]        SEG_DATA,
  output logic              INT
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_RUN   = 2'b10;
  localparam logic [1:0] CMD_PAUSE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [DIGITS-1:0][3:0]   r_dig;
  logic [DIGITS-1:0][3:0]   w_dig_nxt;
  logic [DIGITS-1:0][3:0]   w_stepped;
  logic [DIGITS-1:0][3:0]   w_load_dig;
  logic [PRE_W-1:0]         r_presc;
  logic [PRE_W-1:0]         w_presc_nxt;
  logic                     r_paused;
  logic                     w_paused_nxt;
  logic [1:0]               r_cmd;
  logic                     r_dir;
  logic                     r_int_en;
  logic [15:0]              r_load_lo;
  logic [15:0]              r_load_hi;
  logic                     r_irq;
  logic                     r_stb_q;
  logic [SCN_W-1:0]         r_scan_cnt;
  logic [IDX_W-1:0]         r_scan_idx;

  logic                     w_stb;
  logic                     w_wr;
  logic                     w_rd;
  logic                     w_wr_ctrl;
  logic                     w_clr;
  logic                     w_load;
  logic                     w_irq_set;
  logic                     w_irq_nxt;
  logic                     w_int_en_nxt;
  logic                     w_tick;
  logic                     w_term_now;
  logic                     w_term_step;
  logic [3:0]               w_term_digit;
  logic [31:0]              w_cur;
  logic [31:0]              w_ld_raw;
  logic [15:0]              w_rdata;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'b1111_1100;
      4'd1:    seg_code = 8'b0110_0000;
      4'd2:    seg_code = 8'b1101_1010;
      4'd3:    seg_code = 8'b1111_0010;
      4'd4:    seg_code = 8'b0110_0110;
      4'd5:    seg_code = 8'b1011_0110;
      4'd6:    seg_code = 8'b1011_1110;
      4'd7:    seg_code = 8'b1110_0000;
      4'd8:    seg_code = 8'b1111_1110;
      4'd9:    seg_code = 8'b1111_0110;
      default: seg_code = 8'b0000_0000;
    endcase
  endfunction

  // A write acts only on the first cycle of an asserted strobe
  assign w_stb        = !HOST_nCS && !HOST_nWE && HOST_nOE;
  assign w_wr         = w_stb && !r_stb_q;
  assign w_rd         = !HOST_nCS && !HOST_nOE;
  assign w_wr_ctrl    = w_wr && (HOST_ADD == 4'h0);
  assign w_clr        = w_wr && (HOST_ADD == 4'h6) && HDI[2];
  assign w_tick       = (r_presc == PRE_W'(TICK_DIV - 1));
  assign w_term_digit = r_dir ? 4'd9 : 4'd0;
  assign w_ld_raw     = {r_load_hi, r_load_lo};
  assign w_irq_nxt    = w_irq_set || (r_irq && !(w_clr || w_load));
  assign w_int_en_nxt = w_wr_ctrl ? HDI[3] : r_int_en;

  // Ripple BCD step (borrow down / carry up) plus terminal detection
  always_comb begin : step_calc
    logic v_c;
    v_c         = 1'b1;
    w_stepped   = r_dig;
    w_term_now  = 1'b1;
    w_term_step = 1'b1;
    w_load_dig  = '0;
    w_cur       = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v_c) begin
        if (r_dir) begin
          if (r_dig[i] == 4'd9) begin
            w_stepped[i] = 4'd0;
          end else begin
            w_stepped[i] = r_dig[i] + 4'd1;
            v_c          = 1'b0;
          end
        end else begin
          if (r_dig[i] == 4'd0) begin
            w_stepped[i] = 4'd9;
          end else begin
            w_stepped[i] = r_dig[i] - 4'd1;
            v_c          = 1'b0;
          end
        end
      end
      if (r_dig[i] != w_term_digit) w_term_now = 1'b0;
      if (w_stepped[i] != w_term_digit) w_term_step = 1'b0;
      w_load_dig[i] = (w_ld_raw[i*4 +: 4] > 4'd9) ? 4'd9 : w_ld_raw[i*4 +: 4];
      w_cur[i*4 +: 4] = r_dig[i];
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (!nRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command consumption has priority over the count step
  always_comb begin : fsm_next
    w_state_nxt  = r_state;
    w_dig_nxt    = r_dig;
    w_presc_nxt  = r_presc;
    w_paused_nxt = r_paused;
    w_irq_set    = 1'b0;
    w_load       = 1'b0;
    if (r_cmd == CMD_LOAD) begin
      w_load       = 1'b1;
      w_state_nxt  = ST_READY;
      w_dig_nxt    = w_load_dig;
      w_presc_nxt  = '0;
      w_paused_nxt = 1'b0;
    end else if ((r_cmd == CMD_PAUSE) && (r_state == ST_RUN)) begin
      w_state_nxt  = ST_READY;
      w_paused_nxt = 1'b1;
    end else if ((r_cmd == CMD_RUN) && (r_state == ST_READY)) begin
      w_state_nxt = ST_RUN;
      if (!r_paused) w_presc_nxt = '0;
    end else if (r_state == ST_RUN) begin
      if (w_tick) begin
        w_presc_nxt = '0;
        if (w_term_now) begin
          w_state_nxt = ST_DONE;
          w_irq_set   = 1'b1;
        end else begin
          w_dig_nxt = w_stepped;
          if (w_term_step) begin
            w_state_nxt = ST_DONE;
            w_irq_set   = 1'b1;
          end
        end
      end else begin
        w_presc_nxt = r_presc + PRE_W'(1);
      end
    end
  end

  always_comb begin : read_mux
    w_rdata = '0;
    case (HOST_ADD)
      4'h0:    w_rdata = {12'd0, r_int_en, r_dir, r_cmd};
      4'h1:    w_rdata = r_load_lo;
      4'h2:    w_rdata = r_load_hi;
      4'h4:    w_rdata = w_cur[15:0];
      4'h5:    w_rdata = w_cur[31:16];
      4'h6:    w_rdata = {13'd0, r_irq, r_state};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin : regs
    if (!nRESET) begin
      r_stb_q    <= 1'b0;
      r_cmd      <= '0;
      r_dir      <= 1'b0;
      r_int_en   <= 1'b0;
      r_load_lo  <= '0;
      r_load_hi  <= '0;
      r_dig      <= '0;
      r_presc    <= '0;
      r_paused   <= 1'b0;
      r_irq      <= 1'b0;
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
      HDO        <= '0;
      SEG_COM    <= '1;
      SEG_DATA   <= '0;
      INT        <= 1'b0;
    end else begin
      r_stb_q  <= w_stb;
      r_cmd    <= w_wr_ctrl ? HDI[1:0] : 2'b00;
      r_int_en <= w_int_en_nxt;
      if (w_wr_ctrl) r_dir <= HDI[2];
      if (w_wr && (HOST_ADD == 4'h1)) r_load_lo <= HDI;
      if (w_wr && (HOST_ADD == 4'h2)) r_load_hi <= HDI;
      r_dig    <= w_dig_nxt;
      r_presc  <= w_presc_nxt;
      r_paused <= w_paused_nxt;
      r_irq    <= w_irq_nxt;
      INT      <= w_irq_nxt && w_int_en_nxt;
      if (w_rd) HDO <= w_rdata;
      // Digit select and segment data change on the same edge
      if (r_scan_cnt == SCN_W'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_scan_idx <= (r_scan_idx == IDX_W'(DIGITS - 1)) ? '0 : r_scan_idx + IDX_W'(1);
      end else begin
        r_scan_cnt <= r_scan_cnt + SCN_W'(1);
      end
      SEG_COM  <= ~(DIGITS'(1) << r_scan_idx);
      SEG_DATA <= seg_code(r_dig[r_scan_idx]);
    end
  end

endmodule

// File: tb/tb_bcd_timer_seg_ctl.sv
// Bench for bcd_timer_seg_ctl: directed scenarios plus random bus traffic,
// every cycle compared against an integer-valued reference model.
module tb_bcd_timer_seg_ctl;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned SCAN_DIV = 2;
  localparam int          MODV     = 10000;

  logic              clk;
  logic              nRESET;
  logic              HOST_nCS;
  logic              HOST_nWE;
  logic              HOST_nOE;
  logic [3:0]        HOST_ADD;
  logic [15:0]       HDI;
  logic [15:0]       HDO;
  logic [DIGITS-1:0] SEG_COM;
  logic [7:0]        SEG_DATA;
  logic              INT;

  int n_checks = 0;
  int n_errors = 0;

  bcd_timer_seg_ctl #(
    .DIGITS  (DIGITS),
    .TICK_DIV(TICK_DIV),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk     (clk),
    .nRESET  (nRESET),
    .HOST_nCS(HOST_nCS),
    .HOST_nWE(HOST_nWE),
    .HOST_nOE(HOST_nOE),
    .HOST_ADD(HOST_ADD),
    .HDI     (HDI),
    .HDO     (HDO),
    .SEG_COM (SEG_COM),
    .SEG_DATA(SEG_DATA),
    .INT     (INT)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: timer value is a plain integer 0..10^DIGITS-1
  int m_valid = 0;
  int m_val, m_state, m_irq, m_int_en, m_dir, m_pend, m_presc, m_paused;
  int m_load_lo, m_load_hi, m_prev_stb, m_cyc;
  int e_hdo, e_com, e_data, e_int;
  int seg_tab[10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  function automatic int p10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int to_bcd(input int v, input int first);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) r = r | (((v / p10(first + i)) % 10) << (4 * i));
    return r;
  endfunction

  function automatic int load_value(input int lo, input int hi);
    int raw, nib, v;
    raw = (hi << 16) | lo;
    v = 0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      nib = (raw >> (4 * i)) & 15;
      if (nib > 9) nib = 9;
      v = v + nib * p10(i);
    end
    return v;
  endfunction

  function automatic int reg_read(input int a);
    case (a)
      0:       return (m_int_en << 3) | (m_dir << 2) | m_pend;
      1:       return m_load_lo;
      2:       return m_load_hi;
      4:       return to_bcd(m_val, 0);
      5:       return to_bcd(m_val, 4);
      6:       return (m_irq << 2) | m_state;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int stb, wr, idx, term, irq_set, ld, clr;
    if (!nRESET) begin
      m_val = 0; m_state = 0; m_irq = 0; m_int_en = 0; m_dir = 0; m_pend = 0;
      m_presc = 0; m_paused = 0; m_load_lo = 0; m_load_hi = 0; m_prev_stb = 0;
      m_cyc = 0; e_hdo = 0; e_com = 15; e_data = 0; e_int = 0; m_valid = 1;
    end else begin
      stb = (!HOST_nCS && !HOST_nWE && HOST_nOE) ? 1 : 0;
      wr  = (stb == 1 && m_prev_stb == 0) ? 1 : 0;
      m_prev_stb = stb;
      idx    = (m_cyc / SCAN_DIV) % DIGITS;
      m_cyc  = m_cyc + 1;
      e_com  = 15 & ~(1 << idx);
      e_data = seg_tab[(m_val / p10(idx)) % 10];
      if (!HOST_nCS && !HOST_nOE) e_hdo = reg_read(int'(HOST_ADD));
      term = (m_dir != 0) ? MODV - 1 : 0;
      irq_set = 0; ld = 0; clr = 0;
      if (m_pend == 1) begin
        ld = 1; m_val = load_value(m_load_lo, m_load_hi);
        m_state = 1; m_presc = 0; m_paused = 0;
      end else if (m_pend == 3 && m_state == 2) begin
        m_state = 1; m_paused = 1;
      end else if (m_pend == 2 && m_state == 1) begin
        m_state = 2;
        if (m_paused == 0) m_presc = 0;
      end else if (m_state == 2) begin
        if (m_presc == TICK_DIV - 1) begin
          m_presc = 0;
          if (m_val != term) m_val = (m_dir != 0) ? (m_val + 1) % MODV : (m_val + MODV - 1) % MODV;
          if (m_val == term) begin m_state = 3; irq_set = 1; end
        end else begin
          m_presc = m_presc + 1;
        end
      end
      m_pend = 0;
      if (wr == 1) begin
        case (int'(HOST_ADD))
          0: begin m_pend = int'(HDI[1:0]); m_dir = int'(HDI[2]); m_int_en = int'(HDI[3]); end
          1: m_load_lo = int'(HDI);
          2: m_load_hi = int'(HDI);
          6: clr = int'(HDI[2]);
          default: ;
        endcase
      end
      if (irq_set == 1) m_irq = 1;
      else if (clr == 1 || ld == 1) m_irq = 0;
      e_int = m_irq & m_int_en;
    end
  end

  always @(negedge clk) begin : monitor
    if (m_valid != 0) begin
      chk("mon_hdo", 32'(HDO), 32'(e_hdo));
      chk("mon_seg_com", 32'(SEG_COM), 32'(e_com));
      chk("mon_seg_data", 32'(SEG_DATA), 32'(e_data));
      chk("mon_int", 32'(INT), 32'(e_int));
    end
  end

  task automatic bus_idle();
    HOST_nCS = 1'b1; HOST_nWE = 1'b1; HOST_nOE = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; leaves one idle edge so the next write is a new strobe
  task automatic wr(input logic [3:0] a, input logic [15:0] d, input int hold = 1);
    HOST_nCS = 1'b0; HOST_nWE = 1'b0; HOST_nOE = 1'b1; HOST_ADD = a; HDI = d;
    repeat (hold) @(negedge clk);
    bus_idle();
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] d);
    HOST_nCS = 1'b0; HOST_nWE = 1'b1; HOST_nOE = 1'b0; HOST_ADD = a;
    @(negedge clk);
    d = HDO;
    bus_idle();
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < budget; i++) begin
      rd(4'h6, v);
      if (v[1:0] == 2'd3) break;
    end
    chk(tag, 32'(v[1:0]), 32'd3);
  endtask

  initial begin : stim
    logic [15:0] v;
    logic [3:0]  a;
    logic [15:0] d;
    logic [3:0]  exp_com;
    int          op;
    int          found;
    logic [3:0]  prev_com;
    int          addr_pick[8] = '{0, 0, 0, 1, 2, 6, 4, 7};

    nRESET = 1'b0; bus_idle(); HOST_ADD = '0; HDI = '0;
    repeat (3) @(negedge clk);
    chk("rst_hdo", 32'(HDO), 32'h0);
    chk("rst_com", 32'(SEG_COM), 32'hF);
    chk("rst_data", 32'(SEG_DATA), 32'h0);
    chk("rst_int", 32'(INT), 32'h0);
    nRESET = 1'b1;
    rd(4'h6, v); chk("rst_status", 32'(v), 32'h0);

    // Countdown with borrow, exact first-step latency
    wr(4'h1, 16'h0102); wr(4'h0, 16'h0009);
    rd(4'h6, v); chk("ld_state", 32'(v), 32'h1);
    wr(4'h0, 16'h000A);
    step(3);
    rd(4'h4, v); chk("down_pre", 32'(v), 32'h0102);
    rd(4'h4, v); chk("down_1", 32'(v), 32'h0101);
    step(3);
    rd(4'h4, v); chk("down_2", 32'(v), 32'h0100);
    step(3);
    rd(4'h4, v); chk("down_borrow", 32'(v), 32'h0099);
    wait_done("down_done", 1000);
    rd(4'h4, v); chk("down_zero", 32'(v), 32'h0000);
    rd(4'h6, v); chk("down_status", 32'(v), 32'h7);
    chk("down_int", 32'(INT), 32'h1);

    // Nibbles above 9 load as 9; LOAD clears the pending irq
    wr(4'h1, 16'hAF3C); wr(4'h0, 16'h0009);
    rd(4'h4, v); chk("clamp_cur", 32'(v), 32'h9939);
    rd(4'h1, v); chk("clamp_raw", 32'(v), 32'hAF3C);
    rd(4'h0, v); chk("ctrl_rb", 32'(v), 32'h0008);
    chk("clamp_int", 32'(INT), 32'h0);

    // Up mode to all nines, interrupt masked
    wr(4'h1, 16'h9997); wr(4'h0, 16'h0005); wr(4'h0, 16'h0006);
    step(4);
    rd(4'h4, v); chk("up_1", 32'(v), 32'h9998);
    wait_done("up_done", 100);
    rd(4'h4, v); chk("up_nines", 32'(v), 32'h9999);
    rd(4'h6, v); chk("up_status", 32'(v), 32'h7);
    chk("up_int", 32'(INT), 32'h0);

    // Pause with prescaler at 2, resume keeps it
    wr(4'h1, 16'h0500); wr(4'h0, 16'h0009); wr(4'h0, 16'h000A);
    step(1);
    wr(4'h0, 16'h000B);
    step(20);
    rd(4'h4, v); chk("pause_hold", 32'(v), 32'h0500);
    rd(4'h6, v); chk("pause_state", 32'(v), 32'h1);
    wr(4'h0, 16'h000A);
    step(1);
    rd(4'h4, v); chk("resume_pre", 32'(v), 32'h0500);
    rd(4'h4, v); chk("resume_step", 32'(v), 32'h0499);

    // Clear landing on the terminal edge: set wins; a later clear drops INT
    wr(4'h1, 16'h0001); wr(4'h0, 16'h0009); wr(4'h0, 16'h000A);
    step(3);
    wr(4'h6, 16'h0004);
    chk("setwins_int", 32'(INT), 32'h1);
    rd(4'h6, v); chk("setwins_status", 32'(v), 32'h7);
    wr(4'h6, 16'h0004);
    chk("clr_int", 32'(INT), 32'h0);
    rd(4'h6, v); chk("clr_status", 32'(v), 32'h3);

    // Running from the terminal value finishes after one tick, unchanged
    wr(4'h1, 16'h0000); wr(4'h0, 16'h0009); wr(4'h0, 16'h000A);
    step(3);
    rd(4'h6, v); chk("term_run", 32'(v), 32'h2);
    rd(4'h6, v); chk("term_done", 32'(v), 32'h7);
    rd(4'h4, v); chk("term_val", 32'(v), 32'h0000);

    // Scan order and digit0 = 2 segment pattern
    wr(4'h1, 16'h0002); wr(4'h0, 16'h0001);
    found = 0;
    prev_com = SEG_COM;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (SEG_COM == 4'b1110 && prev_com != 4'b1110) begin found = 1; break; end
      prev_com = SEG_COM;
    end
    chk("scan_find", 32'(found), 32'd1);
    for (int k = 0; k < 9; k++) begin
      exp_com = ~(4'b0001 << (k % 8) / 2);
      chk("scan_com", 32'(SEG_COM), 32'(exp_com));
      if (k < 2) chk("scan_d0", 32'(SEG_DATA), 32'hDA);
      @(negedge clk);
    end

    // Held write strobe acts once: cmd already consumed when the hold ends
    HOST_nCS = 1'b0; HOST_nWE = 1'b0; HOST_nOE = 1'b1; HOST_ADD = 4'h0; HDI = 16'h0009;
    repeat (5) @(negedge clk);
    HOST_nWE = 1'b1; HOST_nOE = 1'b0;
    @(negedge clk);
    chk("hold_cmd", 32'(HDO), 32'h0008);
    bus_idle();
    rd(4'h6, v); chk("hold_state", 32'(v), 32'h1);

    // Reset mid-run
    wr(4'h1, 16'h0300); wr(4'h0, 16'h0009); wr(4'h0, 16'h000A);
    step(6);
    nRESET = 1'b0;
    @(negedge clk);
    chk("mrst_com", 32'(SEG_COM), 32'hF);
    chk("mrst_int", 32'(INT), 32'h0);
    chk("mrst_hdo", 32'(HDO), 32'h0);
    nRESET = 1'b1;
    rd(4'h6, v); chk("mrst_state", 32'(v), 32'h0);
    rd(4'h4, v); chk("mrst_cur", 32'(v), 32'h0);

    // Random traffic, checked cycle by cycle against the model
    for (int k = 0; k < 400; k++) begin
      op = int'($urandom_range(0, 19));
      if (op < 8) begin
        a = 4'(addr_pick[$urandom_range(0, 7)]);
        d = 16'($urandom);
        if (a == 4'h0) d = 16'($urandom_range(0, 15));
        else if (a == 4'h1 && $urandom_range(0, 2) != 0)
          d = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3)) : (16'h9990 | 16'($urandom_range(6, 9)));
        wr(a, d, int'($urandom_range(1, 3)));
      end else if (op < 12) begin
        rd(4'($urandom_range(0, 15)), v);
      end else if (op < 19) begin
        step(int'($urandom_range(1, 16)));
      end else begin
        nRESET = 1'b0;
        @(negedge clk);
        nRESET = 1'b1;
      end
    end
    step(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
